rng_arbiter: RTL

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rng_arbiter.sv
// Round-robin arbiter that hands out words from an external LFSR, sequencing its
// seeding, warm-up and per-grant stepping so consecutive words are LEN steps apart.
module rng_arbiter #(
    parameter int unsigned    LEN          = 8,
    parameter int unsigned    NREQ         = 4,
    parameter logic [LEN-1:0] DEFAULT_SEED = 8'h01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic [LEN-1:0]  data,
    input  logic [LEN-1:0]  seed_in,
    input  logic            seed_load,
    output logic            seed_busy,
    input  logic [LEN-1:0]  lfsr_q,
    output logic            lfsr_en,
    output logic            lfsr_rst,
    output logic [LEN-1:0]  lfsr_seed
);

    localparam int unsigned CW = $clog2(LEN + 1);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {StSeed, StWarmup, StIdle, StServe} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LEN-1:0]  seed_sel_q, seed_sel_d;
    logic [LEN-1:0]  latched_q, latched_d;
    logic            pend_q, pend_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [LEN-1:0]  data_q, data_d;

    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   idx;

    // Search starts one past the last winner and wraps at NREQ-1.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seed_sel_d = seed_sel_q;
        latched_d  = latched_q;
        pend_d     = pend_q;
        last_d     = last_q;
        ack_d      = '0;
        data_d     = data_q;
        lfsr_en    = 1'b0;
        lfsr_rst   = 1'b0;
        lfsr_seed  = seed_sel_q;
        seed_busy  = (state_q != StIdle) || pend_q;

        if (seed_load) begin
            pend_d    = 1'b1;
            latched_d = seed_in;
        end

        unique case (state_q)
            StSeed: begin
                lfsr_rst = 1'b1;
                cnt_d    = '0;
                state_d  = StWarmup;
            end
            StWarmup, StServe: begin
                lfsr_en = 1'b1;
                if (cnt_q == CW'(LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (lfsr_q == '0) begin
                    seed_sel_d = DEFAULT_SEED;
                    state_d    = StSeed;
                end else if (pend_q) begin
                    // A fresh pulse in this same cycle keeps the reseed pending.
                    if (!seed_load) pend_d = 1'b0;
                    seed_sel_d = (latched_q == '0) ? DEFAULT_SEED : latched_q;
                    state_d    = StSeed;
                end else if (found) begin
                    ack_d[winner] = 1'b1;
                    data_d        = lfsr_q;
                    last_d        = winner;
                    cnt_d         = '0;
                    state_d       = StServe;
                end
            end
            default: state_d = StSeed;
        endcase

        if (rst) begin
            lfsr_rst  = 1'b1;
            lfsr_en   = 1'b0;
            lfsr_seed = DEFAULT_SEED;
            seed_busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSeed;
            cnt_q      <= '0;
            seed_sel_q <= DEFAULT_SEED;
            latched_q  <= DEFAULT_SEED;
            pend_q     <= 1'b0;
            last_q     <= IW'(NREQ - 1);
            ack_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seed_sel_q <= seed_sel_d;
            latched_q  <= latched_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
        end
    end

    assign ack  = ack_q;
    assign data = data_q;

endmodule
